// File: rtl/rel_fifo.sv
// Reliable FIFO: triplicated, cross-voted control state (pointers, occupancy) with single-copy payload storage.
// Optional synchronous flush is compiled in when REL_FIFO_FLUSH_EN is defined.
module rel_fifo #(
   parameter type         T            = logic,
   parameter int unsigned Depth        = 4,
   parameter bit          TmrHandshake = 1'b1,
   parameter int unsigned HsWidth      = TmrHandshake ? 3 : 1,
   parameter int unsigned CntWidth     = $clog2(Depth + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [HsWidth-1:0]  flush_i,
   input  logic [HsWidth-1:0]  valid_i,
   output logic [HsWidth-1:0]  ready_o,
   input  T                    data_i,
   output logic [HsWidth-1:0]  valid_o,
   input  logic [HsWidth-1:0]  ready_i,
   output T                    data_o,
   output logic [CntWidth-1:0] usage_o,
   output logic                fault_o
);

   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned DataWidth = $bits(T);

   typedef logic [PtrWidth-1:0] ptr_t;
   typedef logic [CntWidth-1:0] cnt_t;

   localparam ptr_t LastPtr = ptr_t'(Depth - 1);
   localparam cnt_t Full    = cnt_t'(Depth);

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   function automatic logic dis3(input logic [2:0] v);
      return (|v) & ~(&v);
   endfunction

   logic [2:0][PtrWidth-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [2:0][CntWidth-1:0] cnt_q, cnt_d;
   logic [Depth-1:0][DataWidth-1:0] mem_q;

   ptr_t wr_v, rd_v, wr_inc, rd_inc;
   cnt_t cnt_v, cnt_up, cnt_dn;
   logic [2:0] push, pop, rdy_rep, vld_rep;
   logic push_v, flush_v, flush_fault, ctrl_fault, out_fault;
   logic rdy_v, vld_v;

   // Bitwise majority of the three registered replicas
   assign wr_v  = (wr_q[0] & wr_q[1]) | (wr_q[0] & wr_q[2]) | (wr_q[1] & wr_q[2]);
   assign rd_v  = (rd_q[0] & rd_q[1]) | (rd_q[0] & rd_q[2]) | (rd_q[1] & rd_q[2]);
   assign cnt_v = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);

   assign ctrl_fault = (wr_q[0] != wr_q[1]) | (wr_q[0] != wr_q[2])
                     | (rd_q[0] != rd_q[1]) | (rd_q[0] != rd_q[2])
                     | (cnt_q[0] != cnt_q[1]) | (cnt_q[0] != cnt_q[2]);

   assign rdy_v  = cnt_v < Full;
   assign vld_v  = cnt_v != '0;
   assign wr_inc = (wr_v == LastPtr) ? '0 : wr_v + 1'b1;
   assign rd_inc = (rd_v == LastPtr) ? '0 : rd_v + 1'b1;
   assign cnt_up = cnt_v + 1'b1;
   assign cnt_dn = cnt_v - 1'b1;

`ifdef REL_FIFO_FLUSH_EN
   logic [2:0] flush_rep;
   for (genvar i = 0; i < 3; i++) begin : g_flush
      assign flush_rep[i] = flush_i[TmrHandshake ? i : 0];
   end
   assign flush_v     = maj3(flush_rep);
   assign flush_fault = dis3(flush_rep);
`else
   logic unused_flush;
   assign unused_flush = ^flush_i;
   assign flush_v      = 1'b0;
   assign flush_fault  = 1'b0;
`endif

   // Every replica steps from the voted state, so a single upset is overwritten on the next edge
   for (genvar i = 0; i < 3; i++) begin : g_rep
      assign rdy_rep[i] = cnt_q[i] < Full;
      assign vld_rep[i] = cnt_q[i] != '0;
      assign push[i]    = valid_i[TmrHandshake ? i : 0] & rdy_v;
      assign pop[i]     = ready_i[TmrHandshake ? i : 0] & vld_v;
      assign wr_d[i]    = flush_v ? '0 : (push[i] ? wr_inc : wr_v);
      assign rd_d[i]    = flush_v ? '0 : (pop[i] ? rd_inc : rd_v);
      assign cnt_d[i]   = flush_v ? '0 :
                          (push[i] == pop[i]) ? cnt_v :
                          (push[i] ? cnt_up : cnt_dn);
   end

   assign push_v = maj3(push);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '0;
      end else if (push_v && !flush_v) begin
         mem_q[wr_v] <= data_i;
      end
   end

   assign data_o  = T'(mem_q[rd_v]);
   assign usage_o = cnt_v;

   if (TmrHandshake) begin : g_hs_tmr
      assign ready_o   = rdy_rep;
      assign valid_o   = vld_rep;
      assign out_fault = 1'b0;
   end else begin : g_hs_single
      assign ready_o   = maj3(rdy_rep);
      assign valid_o   = maj3(vld_rep);
      assign out_fault = dis3(rdy_rep) | dis3(vld_rep);
   end

   assign fault_o = ctrl_fault | dis3(push) | flush_fault | out_fault;

endmodule

// File: tb/tb_rel_fifo.sv
// Self-checking bench for rel_fifo: queue-based reference model plus directed scenarios,
// on a Depth=4 TMR-handshake instance and a Depth=3 single-wire-handshake instance.
module tb_rel_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [2:0] a_flush, a_valid, a_ready_o, a_valid_o, a_ready_i;
   logic [7:0] a_din, a_dout;
   logic [2:0] a_usage;
   logic       a_fault;

   logic       b_flush, b_valid, b_ready_o, b_valid_o, b_ready_i;
   logic [7:0] b_din, b_dout;
   logic [1:0] b_usage;
   logic       b_fault;

   rel_fifo #(.T(logic [7:0]), .Depth(4), .TmrHandshake(1'b1)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .valid_i(a_valid),
      .ready_o(a_ready_o), .data_i(a_din), .valid_o(a_valid_o), .ready_i(a_ready_i),
      .data_o(a_dout), .usage_o(a_usage), .fault_o(a_fault)
   );

   rel_fifo #(.T(logic [7:0]), .Depth(3), .TmrHandshake(1'b0)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .valid_i(b_valid),
      .ready_o(b_ready_o), .data_i(b_din), .valid_o(b_valid_o), .ready_i(b_ready_i),
      .data_o(b_dout), .usage_o(b_usage), .fault_o(b_fault)
   );

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;
   logic [7:0] qa[$];
   logic [7:0] qb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transfers follow the majority of the replicated handshakes
   task automatic model_update();
      bit fl, ps, pp;
      if (!rst_n) begin
         qa.delete();
         qb.delete();
         return;
      end
`ifdef REL_FIFO_FLUSH_EN
      fl = $countones(a_flush) >= 2;
`else
      fl = 1'b0;
`endif
      ps = ($countones(a_valid) >= 2) && (qa.size() < 4);
      pp = ($countones(a_ready_i) >= 2) && (qa.size() > 0);
      if (fl) qa.delete();
      else begin
         if (pp) void'(qa.pop_front());
         if (ps) qa.push_back(a_din);
      end
`ifdef REL_FIFO_FLUSH_EN
      fl = b_flush;
`else
      fl = 1'b0;
`endif
      ps = b_valid && (qb.size() < 3);
      pp = b_ready_i && (qb.size() > 0);
      if (fl) qb.delete();
      else begin
         if (pp) void'(qb.pop_front());
         if (ps) qb.push_back(b_din);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         chk("a_usage", a_usage, qa.size());
         chk("a_valid", a_valid_o, (qa.size() > 0) ? 3'b111 : 3'b000);
         chk("a_ready", a_ready_o, (qa.size() < 4) ? 3'b111 : 3'b000);
         chk("a_fault", a_fault, 0);
         if (qa.size() > 0) chk("a_data", a_dout, qa[0]);
         chk("b_usage", b_usage, qb.size());
         chk("b_valid", b_valid_o, qb.size() > 0);
         chk("b_ready", b_ready_o, qb.size() < 3);
         chk("b_fault", b_fault, 0);
         if (qb.size() > 0) chk("b_data", b_dout, qb[0]);
      end
   end

   task automatic a_idle();
      a_valid = '0; a_ready_i = '0; a_flush = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      a_idle(); a_din = '0;
      b_valid = 1'b0; b_ready_i = 1'b0; b_flush = 1'b0; b_din = '0;
      repeat (2) @(negedge clk);
      chk("rst_a_usage", a_usage, 0);
      chk("rst_a_ready", a_ready_o, 3'b111);
      chk("rst_a_valid", a_valid_o, 3'b000);
      chk("rst_a_data", a_dout, 8'h00);
      chk("rst_a_fault", a_fault, 0);
      chk("rst_b_ready", b_ready_o, 1);
      chk("rst_b_data", b_dout, 8'h00);
      rst_n = 1'b1;
      cmp_en = 1'b1;

      // fill with downstream stalled, then drain in order
      for (int i = 1; i <= 4; i++) begin
         a_valid = 3'b111; a_din = 8'(i);
         step();
      end
      a_idle();
      chk("fill_usage", a_usage, 4);
      chk("fill_ready", a_ready_o, 3'b000);
      a_ready_i = 3'b111;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_data", a_dout, i);
         step();
      end
      chk("drain_valid", a_valid_o, 3'b000);
      a_idle();

      // full: push attempt plus pop in the same cycle
      for (int i = 0; i < 4; i++) begin
         a_valid = 3'b111; a_din = 8'h20 + 8'(i);
         step();
      end
      a_din = 8'h55; a_ready_i = 3'b111;
      step();
      chk("full_pop_usage", a_usage, 3);
      chk("full_pop_head", a_dout, 8'h21);
      a_ready_i = '0; a_din = 8'h66;
      step();
      chk("refill_usage", a_usage, 4);
      a_idle(); a_ready_i = 3'b111;
      repeat (4) step();
      a_idle();
      chk("empty_usage", a_usage, 0);

      // one disagreeing valid replica: flagged, then corrected
      a_valid = 3'b111; a_din = 8'hA0; step();
      a_din = 8'hA1; step();
      a_idle();
      cmp_en = 1'b0;
      a_valid = 3'b010; a_din = 8'hEE;
      #1;
      chk("inj_fault_now", a_fault, 1);
      step();
      a_idle();
      chk("inj_fault_next", a_fault, 1);
      chk("inj_usage", a_usage, 2);
      chk("inj_valid", a_valid_o, 3'b111);
      step();
      chk("inj_fault_clear", a_fault, 0);
      chk("inj_usage2", a_usage, 2);
      chk("inj_head", a_dout, 8'hA0);
      @(negedge clk);
      cmp_en = 1'b1;
      a_ready_i = 3'b111;
      repeat (2) step();
      a_idle();

      // flush with a concurrent push
      for (int i = 0; i < 3; i++) begin
         a_valid = 3'b111; a_din = 8'hB0 + 8'(i);
         step();
      end
      a_flush = 3'b111; a_din = 8'hBF;
      step();
      a_idle();
`ifdef REL_FIFO_FLUSH_EN
      chk("flush_usage", a_usage, 0);
      chk("flush_valid", a_valid_o, 3'b000);
`else
      chk("noflush_usage", a_usage, 4);
`endif
      a_ready_i = 3'b111;
      repeat (4) step();
      a_idle();

      // Depth 3 stream with continuous push and pop
      b_valid = 1'b1; b_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         b_din = 8'(i);
         step();
         chk("stream_usage", b_usage, 1);
         chk("stream_data", b_dout, i);
      end
      b_valid = 1'b0;
      step();
      chk("stream_end", b_usage, 0);
      b_ready_i = 1'b0;

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         a_valid   = {3{$urandom_range(0, 99) < 60}};
         a_ready_i = {3{$urandom_range(0, 99) < 50}};
         a_flush   = {3{$urandom_range(0, 99) < 3}};
         a_din     = 8'($urandom);
         b_valid   = $urandom_range(0, 99) < 55;
         b_ready_i = $urandom_range(0, 99) < 55;
         b_flush   = $urandom_range(0, 99) < 3;
         b_din     = 8'($urandom);
         step();
      end

      // asynchronous reset mid-operation
      a_idle(); b_flush = 1'b0; b_ready_i = 1'b0;
      a_valid = 3'b111; b_valid = 1'b1;
      repeat (2) step();
      a_idle(); b_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      qa.delete(); qb.delete();
      #1;
      chk("arst_a_usage", a_usage, 0);
      chk("arst_a_valid", a_valid_o, 3'b000);
      chk("arst_a_data", a_dout, 8'h00);
      chk("arst_b_usage", b_usage, 0);
      @(negedge clk);
      rst_n = 1'b1;
      a_valid = 3'b111; a_din = 8'h3C;
      step();
      a_idle();
      chk("post_rst_head", a_dout, 8'h3C);
      repeat (2) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
